// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to DIGITS packed BCD digits.
// Each input bit takes one ADJUST cycle and one SHIFT cycle; the result register holds until the next conversion ends.
module bin_to_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  bcd_valid
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADJUST, S_SHIFT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [BW+WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                valid_q, valid_d;

    logic [BW-1:0]       adjusted;
    logic [BW+WIDTH-1:0] shifted;

    // Nibbles never exceed 9 before adjusting, so +3 stays within 4 bits and no carry is needed.
    always_comb begin
        adjusted = work_q[BW+WIDTH-1:WIDTH];
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[WIDTH+4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = work_q[WIDTH+4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {work_q[BW+WIDTH-2:0], 1'b0};

    // NOTE: every signal gets a default at the top of the block, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = {{BW{1'b0}}, bin_in};
                    cnt_d   = CW'(WIDTH);
                    state_d = S_ADJUST;
                end
            end
            S_ADJUST: begin
                work_d  = {adjusted, work_q[WIDTH-1:0]};
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[BW+WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADJUST;
                end
            end
            S_DONE: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench for bin_to_bcd_converter: latency, values, ignored starts,
// back-to-back operation and asynchronous abort.
module tb_bin_to_bcd_converter;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin_in;
    logic [19:0] bcd;
    logic        busy;
    logic        done;
    logic        bcd_valid;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin_in    (bin_in),
        .bcd       (bcd),
        .busy      (busy),
        .done      (done),
        .bcd_valid (bcd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one conversion, sampling 1 ns after each edge from the accepting edge until busy drops.
    // Optionally pulses start with glitch_val for one cycle at index glitch_at.
    task automatic convert(input logic [15:0] v, input int glitch_at, input logic [15:0] glitch_val,
                           output int edges_to_done, output int busy_cycles,
                           output int done_pulses, output int bcd_moves);
        logic [19:0] bcd_before;
        edges_to_done = -1;
        busy_cycles   = 0;
        done_pulses   = 0;
        bcd_moves     = 0;
        @(negedge clk);
        bcd_before = bcd;
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = ~v;
        for (int n = 0; n < 80; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (!busy) break;
            busy_cycles++;
            if (done) begin
                done_pulses++;
                if (edges_to_done < 0) edges_to_done = n;
            end
            if (n < 32 && bcd !== bcd_before) bcd_moves++;
            if (n == glitch_at) begin
                start  = 1'b1;
                bin_in = glitch_val;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bcd, busy, done, bcd_valid} !== {20'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: bcd=%h busy=%b done=%b valid=%b, want 00000 0 0 0", bcd, busy, done, bcd_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, bcd_valid);
        end
    endtask

    task automatic test_zero();
        int e, b, d, m;
        convert(16'd0, -1, 16'd0, e, b, d, m);
        checks++;
        if (e !== 32) begin errors++; $display("FAIL zero_latency: edges=%0d, want 32", e); end
        checks++;
        if (bcd !== 20'h00000) begin errors++; $display("FAIL zero_value: bcd=%h, want 00000", bcd); end
        checks++;
        if (bcd_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: valid=%b, want 1", bcd_valid); end
    endtask

    task automatic test_max();
        int e, b, d, m;
        convert(16'd65535, -1, 16'd0, e, b, d, m);
        checks++;
        if (bcd !== 20'h65535) begin errors++; $display("FAIL max_value: bcd=%h, want 65535", bcd); end
        checks++;
        if (b !== 33) begin errors++; $display("FAIL max_busy: busy cycles=%0d, want 33", b); end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL max_done: done pulses=%0d, want 1", d); end
    endtask

    task automatic test_products();
        int e, b, d, m;
        convert(16'd65025, -1, 16'd0, e, b, d, m);
        checks++;
        if (bcd !== 20'h65025) begin errors++; $display("FAIL prod_255x255: bcd=%h, want 65025", bcd); end
        convert(16'd120, -1, 16'd0, e, b, d, m);
        checks++;
        if (bcd !== 20'h00120) begin errors++; $display("FAIL prod_12x10: bcd=%h, want 00120", bcd); end
        convert(16'd4096, -1, 16'd0, e, b, d, m);
        checks++;
        if (bcd !== 20'h04096) begin errors++; $display("FAIL value_4096: bcd=%h, want 04096", bcd); end
    endtask

    task automatic test_ignore_start();
        int e, b, d, m;
        convert(16'd4660, 10, 16'd9999, e, b, d, m);
        checks++;
        if (bcd !== 20'h04660) begin errors++; $display("FAIL ignore_value: bcd=%h, want 04660", bcd); end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL ignore_done: done pulses=%0d, want 1", d); end
        checks++;
        if (e !== 32) begin errors++; $display("FAIL ignore_latency: edges=%0d, want 32", e); end
    endtask

    task automatic test_back_to_back();
        int e, b, d, m;
        convert(16'd100, -1, 16'd0, e, b, d, m);
        checks++;
        if (bcd !== 20'h00100) begin errors++; $display("FAIL b2b_first: bcd=%h, want 00100", bcd); end
        convert(16'd9, -1, 16'd0, e, b, d, m);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL b2b_hold: bcd moved in %0d cycles, want 0", m); end
        checks++;
        if (e !== 32) begin errors++; $display("FAIL b2b_latency: edges=%0d, want 32", e); end
        checks++;
        if (bcd !== 20'h00009) begin errors++; $display("FAIL b2b_second: bcd=%h, want 00009", bcd); end
    endtask

    task automatic test_reset_mid();
        int e, b, d, m;
        int late_done;
        @(negedge clk);
        bin_in = 16'd54321;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bcd, busy, done, bcd_valid} !== {20'h0, 3'b000}) begin
            errors++;
            $display("FAIL abort_state: bcd=%h busy=%b done=%b valid=%b, want 00000 0 0 0", bcd, busy, done, bcd_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        late_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0 || bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: active cycles=%0d valid=%b, want 0 0", late_done, bcd_valid);
        end
        convert(16'd7, -1, 16'd0, e, b, d, m);
        checks++;
        if (bcd !== 20'h00007 || bcd_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_abort: bcd=%h valid=%b, want 00007 1", bcd, bcd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_products();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
- Sequential double-dabble (shift-add-3) converter. Sits directly downstream of shift_add_multiplier.
- start connects to the multiplier's d_end; bin_in connects to the 16-bit result.
- Converts the product into 5 packed BCD digits for the display/output stage.
- One result bit is consumed per ADJUST/SHIFT pair. The output register holds the last result until the next conversion completes.

Parameters:
- WIDTH, 16, binary input width in bits; the iteration count equals WIDTH.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately regardless of clk
- start  input  1  one-cycle conversion request (driven by d_end); sampled only in IDLE
- bin_in  input  WIDTH  unsigned binary value; captured on the edge that accepts start, may change afterwards
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0], most significant digit in top nibble
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; bcd is valid and updated during this cycle
- bcd_valid  output  1  sticky; set on the first done after reset, cleared only by reset

Behaviour:
- Reset (rst=0) values:
  - state=IDLE
  - bcd=0, busy=0, done=0, bcd_valid=0
  - internal shift register and iteration counter cleared
- Internal datapath:
  - Working register {scratch[4*DIGITS-1:0], bin[WIDTH-1:0]}.
  - Counter is $clog2(WIDTH+1) bits wide.
- IDLE:
  - start=1 at an edge loads bin=bin_in, scratch=0, counter=WIDTH, then moves to ADJUST.
  - start=0 keeps IDLE.
- ADJUST (1 cycle):
  - Every scratch nibble with value >=5 gets +3, all nibbles in parallel.
  - Nibble sums never exceed 4 bits (max 9+3=12); no carry between nibbles.
  - Moves to SHIFT.
- SHIFT (1 cycle):
  - Whole working register shifts left by 1 (bin MSB enters scratch LSB); counter decrements.
  - If the counter was 1 before decrement: bcd <= shifted scratch, then move to DONE.
  - Otherwise return to ADJUST.
- DONE (1 cycle):
  - done=1; bcd_valid <= 1; moves to IDLE.
  - start seen in DONE is ignored; it is not queued.
- Latency:
  - Start accepted at edge E0; DONE entered at edge E0 + 2*WIDTH (32 for WIDTH=16).
  - done high in the cycle following that edge; busy high from E0 until leaving DONE.
  - Earliest next accept is the edge after DONE, so back-to-back throughput is 2*WIDTH+2 cycles per conversion.
- start while busy: ignored, with no effect on the in-flight conversion or on bcd. The upstream multiplier's conversion period (>=17 cycles per product) is shorter than 2*WIDTH+2. An upstream user must check busy or accept dropped products; this block does not buffer.
- bcd changes only on the final SHIFT edge and on reset; it is stable at all other times, including during the next conversion.
- Reset mid-conversion: abort immediately; all outputs go to their reset values; the partial result is discarded.
- Every bcd nibble is in 0..9 at all times.

Test Plan:
- bin_in=16'd0, start pulse -> done exactly 33 cycles after start sampled (32 edges + 1); bcd=20'h00000, bcd_valid=1.
- bin_in=16'd65535 -> bcd=20'h65535; busy high for 33 cycles.
- Multiplier product 255*255: bin_in=16'd65025, start=d_end -> bcd=20'h65025. Then 12*10=120 -> bcd=20'h00120.
- Start 4660 (0x1234), then pulse start with bin_in=9999 at cycle 10 -> second pulse ignored; bcd=20'h04660, exactly one done pulse.
- Start 54321, assert rst=0 at cycle 15 -> bcd=0, busy=0, done never pulses, bcd_valid=0. After release, start 7 -> bcd=20'h00007.
- Back-to-back: start 100, then start 9 at the first IDLE edge after done -> bcd=20'h00100 at first done, then 20'h00009; bcd holds 00100 throughout the second conversion.
